// File: rtl/dm_access_arbiter.sv
// Single-port data memory arbiter: pipeline MEM stage has priority, loader/debug port
// gets a forced slot (optionally a locked burst) after MAX_WAIT blocked cycles.
module dm_access_arbiter #(
  parameter int AW        = 16,
  parameter int DW        = 16,
  parameter int MAX_WAIT  = 4,
  parameter int MAX_BURST = 4
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_pl_en,
  input  logic          i_pl_we,
  input  logic [AW-1:0] i_pl_addr,
  input  logic [DW-1:0] i_pl_wdata,
  output logic          o_pl_stall,
  output logic          o_pl_rvalid,
  input  logic          i_ld_req,
  input  logic          i_ld_lock,
  input  logic          i_ld_we,
  input  logic [AW-1:0] i_ld_addr,
  input  logic [DW-1:0] i_ld_wdata,
  output logic          o_ld_gnt,
  output logic          o_ld_rvalid,
  output logic          o_mem_en,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_din,
  input  logic [DW-1:0] i_mem_dout
);

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT - 1);
  localparam logic [WW-1:0] WAIT_SAT  = WW'(MAX_WAIT);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

  typedef enum logic {PL_PRI = 1'b0, LD_FORCE = 1'b1} state_t;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } mem_req_t;

  state_t        r_fsm;
  logic [WW-1:0] r_wait_cnt;
  logic [BW-1:0] r_burst_cnt;
  logic          r_pl_rd_q;
  logic          r_ld_rd_q;

  logic          w_force_slot;
  logic          w_pl_gnt;
  logic          w_ld_gnt;
  logic [BW-1:0] w_burst_nxt;
  mem_req_t      w_pl_req;
  mem_req_t      w_ld_req;
  mem_req_t      w_mem_req;

  assign w_pl_req = '{we: i_pl_we, addr: i_pl_addr, wdata: i_pl_wdata};
  assign w_ld_req = '{we: i_ld_we, addr: i_ld_addr, wdata: i_ld_wdata};

  // Everything is gated by reset so nothing reaches memory while reset is held.
  assign w_force_slot = (r_fsm == LD_FORCE) & i_ld_req;
  assign w_ld_gnt     = i_reset & (w_force_slot | (~i_pl_en & i_ld_req));
  assign w_pl_gnt     = i_reset & i_pl_en & ~w_force_slot;
  assign w_burst_nxt  = r_burst_cnt + BW'(1);

  always_comb begin
    w_mem_req = '0;
    if (w_pl_gnt)      w_mem_req = w_pl_req;
    else if (w_ld_gnt) w_mem_req = w_ld_req;
  end

  assign o_pl_stall  = i_reset & i_pl_en & w_force_slot;
  assign o_ld_gnt    = w_ld_gnt;
  assign o_mem_en    = w_pl_gnt | w_ld_gnt;
  assign o_mem_we    = w_mem_req.we;
  assign o_mem_addr  = w_mem_req.addr;
  assign o_mem_din   = w_mem_req.wdata;
  assign o_pl_rvalid = r_pl_rd_q;
  assign o_ld_rvalid = r_ld_rd_q;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_fsm       <= PL_PRI;
      r_wait_cnt  <= '0;
      r_burst_cnt <= '0;
      r_pl_rd_q   <= 1'b0;
      r_ld_rd_q   <= 1'b0;
    end else begin
      r_pl_rd_q <= w_pl_gnt & ~i_pl_we;
      r_ld_rd_q <= w_ld_gnt & ~i_ld_we;
      case (r_fsm)
        PL_PRI: begin
          if (i_pl_en & i_ld_req) begin
            if (r_wait_cnt != WAIT_SAT) r_wait_cnt <= r_wait_cnt + WW'(1);
            if (r_wait_cnt == WAIT_LAST) begin
              r_fsm       <= LD_FORCE;
              r_burst_cnt <= '0;
            end
          end else begin
            r_wait_cnt <= '0;
          end
        end
        LD_FORCE: begin
          if (i_ld_req) begin
            r_burst_cnt <= w_burst_nxt;
            if (!(i_ld_lock && (w_burst_nxt < BURST_MAX))) begin
              r_fsm      <= PL_PRI;
              r_wait_cnt <= '0;
            end
          end else begin
            r_fsm      <= PL_PRI;
            r_wait_cnt <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dm_access_arbiter.sv
// Bench for dm_access_arbiter: directed literal checks plus a per-cycle behavioural model
// with a shadow memory, driven by directed and random contention traffic.
module tb_dm_access_arbiter;
  localparam int AW = 16, DW = 16, MW = 4, MB = 4;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          pl_en = 0, pl_we = 0, ld_req = 0, ld_lock = 0, ld_we = 0;
  logic [AW-1:0] pl_addr = '0, ld_addr = '0;
  logic [DW-1:0] pl_wdata = '0, ld_wdata = '0;
  logic          pl_stall, pl_rvalid, ld_gnt, ld_rvalid, mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din, mem_dout;

  int checks = 0, failures = 0;

  dm_access_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MW), .MAX_BURST(MB)) dut (
    .i_clk(clk), .i_reset(rst_n),
    .i_pl_en(pl_en), .i_pl_we(pl_we), .i_pl_addr(pl_addr), .i_pl_wdata(pl_wdata),
    .o_pl_stall(pl_stall), .o_pl_rvalid(pl_rvalid),
    .i_ld_req(ld_req), .i_ld_lock(ld_lock), .i_ld_we(ld_we), .i_ld_addr(ld_addr),
    .i_ld_wdata(ld_wdata), .o_ld_gnt(ld_gnt), .o_ld_rvalid(ld_rvalid),
    .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_din(mem_din),
    .i_mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] init_val(input int a);
    return (a == 16) ? 16'h1234 : 16'((a * 257) ^ 16'h5A5A);
  endfunction

  // Synchronous single-port memory, 1-cycle read latency
  logic [DW-1:0] mem [0:255];
  bit            mwr [0:255];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        mem[mem_addr[7:0]] <= mem_din;
        mwr[mem_addr[7:0]] <= 1'b1;
      end else begin
        mem_dout <= mwr[mem_addr[7:0]] ? mem[mem_addr[7:0]] : init_val(int'(mem_addr[7:0]));
      end
    end
  end

  // ---------------- behavioural model ----------------
  logic [DW-1:0] shadow [int];
  bit  m_force, m_plrd, m_ldrd;
  int  m_wait, m_burst;
  logic [DW-1:0] m_rdata;
  bit  n_force, n_plrd, n_ldrd, n_wr;
  int  n_wait, n_burst, n_wa;
  logic [DW-1:0] n_rdata, n_wd;
  int  stall_run = 0;

  function automatic logic [DW-1:0] shadow_rd(input int a);
    return shadow.exists(a) ? shadow[a] : init_val(a);
  endfunction

  always @(negedge clk) begin
    bit fs, eldg, eplg, est, een, ewe, eplrv, eldrv;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    if (!rst_n) begin
      {fs, eldg, eplg, est, een, ewe, eplrv, eldrv} = '0;
      ea = '0; ed = '0;
      n_force = 0; n_plrd = 0; n_ldrd = 0; n_wr = 0;
      n_wait = 0; n_burst = 0; n_wa = 0; n_rdata = '0; n_wd = '0;
    end else begin
      // a forced slot exists only while the loader still asks for it
      fs   = m_force && ld_req;
      eldg = fs || (!pl_en && ld_req);
      eplg = pl_en && !fs;
      est  = pl_en && fs;
      een  = eldg || eplg;
      ewe  = eplg ? pl_we : (eldg ? ld_we : 1'b0);
      ea   = eplg ? pl_addr : (eldg ? ld_addr : '0);
      ed   = eplg ? pl_wdata : (eldg ? ld_wdata : '0);
      eplrv = m_plrd; eldrv = m_ldrd;
      n_plrd  = eplg && !pl_we;
      n_ldrd  = eldg && !ld_we;
      n_rdata = shadow_rd(int'(ea[7:0]));
      n_wr = een && ewe; n_wa = int'(ea[7:0]); n_wd = ed;
      n_burst = m_burst; n_force = 0; n_wait = 0;
      if (!m_force) begin
        if (pl_en && ld_req) begin
          n_wait  = (m_wait + 1 > MW) ? MW : m_wait + 1;
          n_force = (m_wait + 1 == MW);
          if (n_force) n_burst = 0;
        end
      end else if (ld_req) begin
        n_burst = m_burst + 1;
        n_force = ld_lock && (n_burst < MB);
        n_wait  = n_force ? m_wait : 0;
      end
    end
    chk("mdl_mem_en", mem_en, een);
    chk("mdl_ld_gnt", ld_gnt, eldg);
    chk("mdl_pl_stall", pl_stall, est);
    chk("mdl_pl_rvalid", pl_rvalid, eplrv);
    chk("mdl_ld_rvalid", ld_rvalid, eldrv);
    if (een) begin
      chk("mdl_mem_we", mem_we, ewe);
      chk("mdl_mem_addr", mem_addr, ea);
      if (ewe) chk("mdl_mem_din", mem_din, ed);
    end else begin
      chk("mdl_idle_bus", {mem_we, mem_addr, mem_din}, '0);
    end
    if (eplrv || eldrv) chk("mdl_rdata", mem_dout, m_rdata);
    chk("rvalid_excl", pl_rvalid & ld_rvalid, 0);
    stall_run = pl_stall ? stall_run + 1 : 0;
    chk("stall_run_bound", stall_run <= MB, 1);
  end

  always @(posedge clk) begin
    m_force = n_force; m_wait = n_wait; m_burst = n_burst;
    m_plrd = n_plrd; m_ldrd = n_ldrd; m_rdata = n_rdata;
    if (n_wr) shadow[n_wa] = n_wd;
    n_wr = 0;
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    pl_en = 0; ld_req = 0; ld_lock = 0; pl_we = 0; ld_we = 0;
  endtask

  initial begin
    bit stalled, granted;
    // reset held with both requesters active
    pl_en = 1; ld_req = 1;
    @(negedge clk);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_pl_stall", pl_stall, 0);
    chk("rst_ld_gnt", ld_gnt, 0);
    chk("rst_rvalids", {pl_rvalid, ld_rvalid}, 0);
    step(); rst_n = 1; idle();
    @(negedge clk);
    chk("idle_outputs", {mem_en, mem_we, mem_addr, mem_din, pl_stall, ld_gnt}, 0);

    // pipeline read
    step(); pl_en = 1; pl_we = 0; pl_addr = 16'h0010;
    @(negedge clk);
    chk("plrd_addr", mem_addr, 16'h0010);
    chk("plrd_en", mem_en, 1);
    step(); idle();
    @(negedge clk);
    chk("plrd_rvalid", pl_rvalid, 1);
    chk("plrd_data", mem_dout, 16'h1234);
    chk("plrd_ld_rvalid", ld_rvalid, 0);

    // loader write on idle pipeline, then read back
    step(); ld_req = 1; ld_we = 1; ld_addr = 16'h0020; ld_wdata = 16'hBEEF;
    @(negedge clk);
    chk("ldwr_gnt", ld_gnt, 1);
    chk("ldwr_bus", {mem_we, mem_addr, mem_din}, {1'b1, 16'h0020, 16'hBEEF});
    step(); idle(); pl_en = 1; pl_addr = 16'h0020;
    @(negedge clk);
    chk("ldwr_no_strobe", ld_rvalid, 0);
    step(); idle();
    @(negedge clk);
    chk("rdback_data", mem_dout, 16'hBEEF);
    chk("rdback_rvalid", pl_rvalid, 1);

    // starvation: forced slot at cycle 4, wait restarts, next forced slot at cycle 9
    step(); pl_en = 1; pl_we = 1; pl_addr = 16'h0030; pl_wdata = 16'h1111;
    ld_req = 1; ld_we = 0; ld_addr = 16'h0010; ld_lock = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk($sformatf("starve_gnt_c%0d", c), ld_gnt, (c == 4 || c == 9));
      chk($sformatf("starve_stall_c%0d", c), pl_stall, (c == 4 || c == 9));
      if (c == 5) begin
        chk("starve_ld_rvalid", ld_rvalid, 1);
        chk("starve_ld_data", mem_dout, 16'h1234);
      end
      step();
    end
    idle();
    step();

    // locked burst of MAX_BURST forced slots
    pl_en = 1; pl_we = 0; pl_addr = 16'h0020;
    ld_req = 1; ld_lock = 1; ld_we = 1; ld_addr = 16'h0040; ld_wdata = 16'hCAFE;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      chk($sformatf("burst_gnt_c%0d", c), ld_gnt, (c >= 4 && c <= 7));
      chk($sformatf("burst_stall_c%0d", c), pl_stall, (c >= 4 && c <= 7));
      step();
    end
    idle(); pl_en = 1; pl_addr = 16'h0040;
    step(); idle();
    @(negedge clk);
    chk("burst_wr_data", mem_dout, 16'hCAFE);
    step();

    // burst cut short by loader withdrawing after two grants
    pl_en = 1; pl_we = 0; pl_addr = 16'h0020;
    ld_req = 1; ld_lock = 1; ld_we = 0; ld_addr = 16'h0020;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("cut_gnt_c%0d", c), ld_gnt, (c >= 4));
      step();
    end
    ld_req = 0;
    @(negedge clk);
    chk("cut_wd_gnt", ld_gnt, 0);
    chk("cut_wd_stall", pl_stall, 0);
    chk("cut_wd_ld_rvalid", ld_rvalid, 1);
    step(); ld_req = 1;
    @(negedge clk);
    chk("cut_back_pri_gnt", ld_gnt, 0);
    chk("cut_back_pri_stall", pl_stall, 0);
    step(); idle();

    // random contention traffic with one reset mid-run
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      stalled = pl_stall; granted = ld_gnt;
      step();
      if (n == 700) rst_n = 0;
      if (n == 702) rst_n = 1;
      if (!(pl_en && stalled)) begin
        pl_en    = ($urandom_range(0, 9) < 7);
        pl_we    = 1'($urandom_range(0, 1));
        pl_addr  = 16'($urandom_range(0, 255));
        pl_wdata = 16'($urandom);
      end
      if (!(ld_req && !granted)) begin
        ld_req   = ($urandom_range(0, 9) < 6);
        ld_lock  = 1'($urandom_range(0, 1));
        ld_we    = 1'($urandom_range(0, 1));
        ld_addr  = 16'($urandom_range(0, 255));
        ld_wdata = 16'($urandom);
      end
    end
    idle();
    step();
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
